timer_regs: RTL and testbench

Memory-mapped register front-end for the timer/counter block: it sits directly upstream of the timer, turning processor bus reads and writes into the timer's control inputs (start/halt pulses, mode, terminal count). It also returns the timer's status and current count to software, and latches the timer's one-cycle interrupt pulse into a sticky, maskable interrupt line for the core.

---
 rtl/timer_regs.sv | 131 +++++++++++++
 tb/tb_timer_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regs.sv
// timer_regs: bus register front-end for the timer/counter block.
// Decodes single-beat bus reads/writes into the timer controls: start and halt
// pulses, mode and terminal count. Returns timer status and count to software.
// Latches the timer's terminal-count pulse into a sticky, maskable interrupt.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   bus_req/we/addr/wdata  bus request from master (held until bus_ack)
//   bus_rdata, bus_ack     read data (zero outside the ack cycle), 1-cycle ack
//   ro_trig_start/halt     one-cycle start/halt pulses to timer
//   ro_mode, ro_termcount  timer mode (1 = continuous) and terminal count
//   rf_status, rf_currcount, rf_int  timer running flag, count, terminal pulse
//   irq                    level interrupt = pending & irq_en
module timer_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        ro_trig_start,
    output logic        ro_trig_halt,
    output logic        ro_mode,
    output logic [31:0] ro_termcount,
    input  logic        rf_status,
    input  logic [31:0] rf_currcount,
    input  logic        rf_int,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_TERM    = 2'd1,
        REG_COUNT   = 2'd2,
        REG_INTSTAT = 2'd3
    } reg_sel_e;

    logic              bus_ack_q,   bus_ack_d;
    logic [DATA_W-1:0] bus_rdata_q, bus_rdata_d;
    logic              start_q,     start_d;
    logic              halt_q,      halt_d;
    logic              mode_q,      mode_d;
    logic              irq_en_q,    irq_en_d;
    logic [DATA_W-1:0] term_q,      term_d;
    logic              pending_q,   pending_d;

    logic     accept;
    reg_sel_e reg_sel;

    // Byte-lane bits of the address carry no meaning in this register map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_addr[1:0];

    // Next-state: bus decode, control pulses, sticky pending flag.
    always_comb begin
        accept      = bus_req & ~bus_ack_q;
        reg_sel     = reg_sel_e'(bus_addr[3:2]);
        bus_ack_d   = accept;
        bus_rdata_d = '0;
        start_d     = 1'b0;
        halt_d      = 1'b0;
        mode_d      = mode_q;
        irq_en_d    = irq_en_q;
        term_d      = term_q;
        pending_d   = pending_q;

        if (accept && bus_we) begin
            case (reg_sel)
                REG_CTRL: begin
                    start_d  = bus_wdata[0];
                    // Start takes precedence when both are requested.
                    halt_d   = bus_wdata[1] & ~bus_wdata[0];
                    mode_d   = bus_wdata[2];
                    irq_en_d = bus_wdata[3];
                end
                REG_TERM:    term_d = bus_wdata;
                REG_INTSTAT: if (bus_wdata[0]) pending_d = 1'b0;
                default: ;
            endcase
        end

        if (accept && !bus_we) begin
            case (reg_sel)
                REG_CTRL:    bus_rdata_d = {28'd0, irq_en_q, mode_q, 1'b0, rf_status};
                REG_TERM:    bus_rdata_d = term_q;
                REG_COUNT:   bus_rdata_d = rf_currcount;
                REG_INTSTAT: bus_rdata_d = {31'd0, pending_q};
                default:     bus_rdata_d = '0;
            endcase
        end

        // A new terminal pulse beats a simultaneous software clear.
        if (rf_int) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_ack_q   <= 1'b0;
            bus_rdata_q <= '0;
            start_q     <= 1'b0;
            halt_q      <= 1'b0;
            mode_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            term_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            bus_ack_q   <= bus_ack_d;
            bus_rdata_q <= bus_rdata_d;
            start_q     <= start_d;
            halt_q      <= halt_d;
            mode_q      <= mode_d;
            irq_en_q    <= irq_en_d;
            term_q      <= term_d;
            pending_q   <= pending_d;
        end
    end

    assign bus_ack       = bus_ack_q;
    assign bus_rdata     = bus_rdata_q;
    assign ro_trig_start = start_q;
    assign ro_trig_halt  = halt_q;
    assign ro_mode       = mode_q;
    assign ro_termcount  = term_q;
    // Purely a function of two flops, so glitch-free toward the core.
    assign irq           = pending_q & irq_en_q;

endmodule

// File: tb/tb_timer_regs.sv
// tb_timer_regs: directed stimulus with a transaction-level reference model
// compared against every DUT output each cycle, plus literal expectations.
module tb_timer_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic        ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status = 1'b0;
    logic [31:0] rf_currcount = 32'h0;
    logic        rf_int = 1'b0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] A_CTRL = 4'h0, A_TERM = 4'h4, A_COUNT = 4'h8, A_INT = 4'hC;

    timer_regs dut (
        .clk(clk), .reset(reset),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
        .ro_mode(ro_mode), .ro_termcount(ro_termcount),
        .rf_status(rf_status), .rf_currcount(rf_currcount), .rf_int(rf_int),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents and the expected outputs after each edge.
    logic        model_valid = 1'b0;
    logic        m_ack, m_start, m_halt, m_mode, m_irq_en, m_pend, m_acc, m_new_pend;
    logic [31:0] m_rdata, m_term;
    logic [1:0]  m_reg;

    always @(posedge clk) begin
        if (reset) begin
            model_valid = 1'b1;
            m_ack = 0; m_rdata = 0; m_start = 0; m_halt = 0;
            m_mode = 0; m_irq_en = 0; m_term = 0; m_pend = 0;
        end else begin
            m_acc      = bus_req && !m_ack;
            m_reg      = bus_addr[3:2];
            m_new_pend = m_pend || rf_int;
            m_start    = 0;
            m_halt     = 0;
            m_rdata    = 0;
            if (m_acc && bus_we) begin
                if (m_reg == 2'd0) begin
                    m_start  = bus_wdata[0];
                    m_halt   = bus_wdata[1] && !bus_wdata[0];
                    m_mode   = bus_wdata[2];
                    m_irq_en = bus_wdata[3];
                end else if (m_reg == 2'd1) begin
                    m_term = bus_wdata;
                end else if (m_reg == 2'd3 && bus_wdata[0] && !rf_int) begin
                    m_new_pend = 0;
                end
            end else if (m_acc) begin
                if (m_reg == 2'd0)      m_rdata = 32'(m_irq_en) * 8 + 32'(m_mode) * 4 + 32'(rf_status);
                else if (m_reg == 2'd1) m_rdata = m_term;
                else if (m_reg == 2'd2) m_rdata = rf_currcount;
                else                    m_rdata = 32'(m_pend);
            end
            m_pend = m_new_pend;
            m_ack  = m_acc;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_ack",   32'(bus_ack),       32'(m_ack));
            chk("cyc_rdata", bus_rdata,          m_rdata);
            chk("cyc_start", 32'(ro_trig_start), 32'(m_start));
            chk("cyc_halt",  32'(ro_trig_halt),  32'(m_halt));
            chk("cyc_mode",  32'(ro_mode),       32'(m_mode));
            chk("cyc_term",  ro_termcount,       m_term);
            chk("cyc_irq",   32'(irq),           32'(m_pend && m_irq_en));
        end
    end

    // One bus transaction; returns at the negedge inside the ack cycle.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            input logic int_pulse, output logic [31:0] rd);
        logic got;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        if (int_pulse) rf_int = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            rf_int = 1'b0;
            if (bus_ack) got = 1'b1;
        end
        rd = bus_rdata;
        bus_req = 1'b0; bus_we = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no bus_ack expected ack within 8 cycles addr=0x%0h", addr);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        bus_xfer(1'b1, addr, wd, 1'b0, d);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(1'b0, addr, 32'h0, 1'b0, d);
        chk(name, d, exp);
    endtask

    task automatic pulse_int();
        @(negedge clk); rf_int = 1'b1;
        @(negedge clk); rf_int = 1'b0;
    endtask

    logic [31:0] tmp;
    logic [5:0]  pattern;
    int          acks;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_chk("rst_ctrl",  A_CTRL,  32'h0);
        rd_chk("rst_term",  A_TERM,  32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);
        rd_chk("rst_int",   A_INT,   32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_mode", 32'(ro_mode), 32'h0);
        chk("rst_termcount", ro_termcount, 32'h0);

        // One-shot run to terminal count
        wr(A_TERM, 32'd5);
        chk("os_term", ro_termcount, 32'd5);
        wr(A_CTRL, 32'h9);
        chk("os_start_hi", 32'(ro_trig_start), 32'h1);
        @(negedge clk);
        chk("os_start_lo", 32'(ro_trig_start), 32'h0);
        rf_status = 1'b1;
        repeat (5) @(negedge clk);
        pulse_int();
        chk("os_irq", 32'(irq), 32'h1);
        rf_status = 1'b0;
        rd_chk("os_intstat", A_INT, 32'h1);
        rd_chk("os_ctrl", A_CTRL, 32'h8);

        // W1C racing a new terminal pulse
        bus_xfer(1'b1, A_INT, 32'h1, 1'b1, tmp);
        rd_chk("race_pend", A_INT, 32'h1);
        wr(A_INT, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);
        rd_chk("w1c_pend", A_INT, 32'h0);
        pulse_int();
        wr(A_INT, 32'h0);
        rd_chk("w0_pend", A_INT, 32'h1);
        wr(A_INT, 32'h1);

        // Continuous run, then halt; start+halt pulses start only
        wr(A_TERM, 32'd3);
        wr(A_CTRL, 32'hD);
        chk("cont_mode", 32'(ro_mode), 32'h1);
        rf_status = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rf_currcount = 32'(i % 4);
        end
        wr(A_CTRL, 32'h2);
        chk("halt_hi", 32'(ro_trig_halt), 32'h1);
        chk("halt_nostart", 32'(ro_trig_start), 32'h0);
        chk("halt_mode", 32'(ro_mode), 32'h0);
        @(negedge clk);
        chk("halt_lo", 32'(ro_trig_halt), 32'h0);
        rf_status = 1'b0; rf_currcount = 32'h0;
        rd_chk("halt_count", A_COUNT, 32'h0);
        rf_currcount = 32'hDEAD_BEEF;
        rd_chk("count_val", A_COUNT, 32'hDEAD_BEEF);
        rd_chk("halt_ctrl", A_CTRL, 32'h0);
        wr(A_COUNT, 32'hFFFF_FFFF);
        rd_chk("term_alias", 4'h7, 32'd3);
        wr(A_CTRL, 32'h3);
        chk("both_start", 32'(ro_trig_start), 32'h1);
        chk("both_nohalt", 32'(ro_trig_halt), 32'h0);

        // Masking keeps pending
        wr(A_CTRL, 32'h8);
        pulse_int();
        chk("mask_irq_on", 32'(irq), 32'h1);
        wr(A_CTRL, 32'h0);
        chk("mask_irq_off", 32'(irq), 32'h0);
        rd_chk("mask_pend", A_INT, 32'h1);
        wr(A_CTRL, 32'h8);
        @(negedge clk);
        chk("unmask_irq", 32'(irq), 32'h1);

        // bus_req held across three writes
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_TERM; bus_wdata = 32'hA1;
        pattern = '0; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pattern = {pattern[4:0], bus_ack};
            if (bus_ack) begin
                acks++;
                chk("burst_upd", ro_termcount, bus_wdata);
                if (acks == 1)      bus_wdata = 32'hB2;
                else if (acks == 2) bus_wdata = 32'hC3;
                else begin bus_req = 1'b0; bus_we = 1'b0; end
            end
        end
        bus_req = 1'b0; bus_we = 1'b0;
        chk("burst_pattern", 32'(pattern), 32'h2A);
        chk("burst_acks", 32'(acks), 32'd3);
        chk("burst_term", ro_termcount, 32'hC3);

        // Reset aborts a pending read
        wr(A_CTRL, 32'hC);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_TERM; reset = 1'b1;
        @(negedge clk);
        chk("rstx_ack", 32'(bus_ack), 32'h0);
        chk("rstx_rdata", bus_rdata, 32'h0);
        chk("rstx_mode", 32'(ro_mode), 32'h0);
        chk("rstx_term", ro_termcount, 32'h0);
        chk("rstx_irq", 32'(irq), 32'h0);
        bus_req = 1'b0;
        @(negedge clk);
        chk("rstx_ack2", 32'(bus_ack), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstx_ack3", 32'(bus_ack), 32'h0);
        rd_chk("rstx_readback", A_TERM, 32'h0);
        rd_chk("rstx_int", A_INT, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
